uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte-buffered UART transmitter (8N1) sitting directly downstream of the sensor crossbar. It accepts result bytes (sensor data bytes, 0x0D separators) over a valid/ready handshake into a small FIFO and serializes them onto the board's UART TX pin at a fixed baud rate. `tx_ready` is the crossbar's flow-control signal: while it is high, the crossbar may push a byte every cycle.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115_200: line rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD`, integer-truncated, must be ≥ 2.
- `FIFO_DEPTH`, 8: byte entries. Must be a power of two, ≥ 2.
- `clk`, in, 1: system clock, rising-edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `tx_data`, in, 8: byte to enqueue.
- `tx_valid`, in, 1: `tx_data` is valid this cycle.
- `tx_ready`, out, 1: FIFO not full; a write is accepted on an edge where `tx_valid && tx_ready`.
- `txd`, out, 1: serial line; idle high.
- `busy`, out, 1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`, out, $clog2(FIFO_DEPTH+1): current occupancy.
- `overflow`, out, 1: one-cycle pulse when `tx_valid` is high while `tx_ready` is low. The byte is dropped.

## Operation
- FIFO: circular buffer with read/write pointers of width $clog2(FIFO_DEPTH). Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` is a registered value.
  - `tx_ready` = (`fifo_count` != `FIFO_DEPTH`), combinational from the registered count.
  - A write and a pop on the same edge leave the count unchanged.
  - A write while full is ignored and pulses `overflow`. FIFO contents are unchanged.
- Serializer FSM states: IDLE, START, DATA, STOP. It uses a baud counter (0..`CLKS_PER_BIT`-1), a bit index (0..7) and an 8-bit shift register.
  - IDLE: `txd`=1. If the FIFO is non-empty, on the edge: pop the head into the shift register, set `txd`<=0, clear the baud counter, go to START.
  - START: hold `txd`=0 for `CLKS_PER_BIT` cycles. Then `txd`<=shift[0], bit index<=0, go to DATA.
  - DATA: each bit is held for `CLKS_PER_BIT` cycles, LSB first. At the end of a bit period: if bit index=7, set `txd`<=1 and go to STOP; otherwise shift right, increment the index and output the next bit.
  - STOP: hold `txd`=1 for `CLKS_PER_BIT` cycles. At the end of the period, if the FIFO is non-empty, pop and start the next frame exactly as in IDLE, with zero idle cycles between frames. Otherwise go to IDLE.
- A pop happens only in IDLE or at the end of STOP, and only when `fifo_count` > 0. An empty FIFO is never popped.
- `busy` = (state != IDLE) || (`fifo_count` != 0).
- There is no bypass path: a byte always passes through the FIFO.

## Timing
- Reset values (applied immediately, asynchronously): `txd`=1, `busy`=0, `fifo_count`=0, `tx_ready`=1, `overflow`=0, FSM=IDLE, pointers=0. Reset mid-frame aborts the frame, drives the line high and discards the FIFO contents.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. `txd` falls after edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames have period 10×`CLKS_PER_BIT`.
- `fifo_count` updates on the accept/pop edge. `tx_ready` follows in the same cycle.
- `overflow` is asserted during the cycle following the rejected edge, for exactly one cycle per rejected beat.

## Test plan
All scenarios use `CLK_FREQ_HZ`=1000, `BAUD`=100 (10 clocks/bit), `FIFO_DEPTH`=4.
- Single byte 0x54 written into an empty FIFO → `txd` is low 10 cycles, then bits 0,0,1,0,1,0,1,0 for 10 cycles each, then high 10 cycles. The falling edge is one cycle after the write edge. `busy` drops after the stop bit.
- Bytes 0x31, 0x32, 0x0D written on consecutive cycles → three frames with no idle gap, 300 cycles total. `fifo_count` goes 1,1,2 (first byte popped immediately), then decrements at each frame boundary.
- Write 5 bytes while the FSM is busy and the FIFO is already holding 4 → the 5th is dropped. `tx_ready`=0 at count 4. `overflow` pulses once. Exactly the first 4 bytes appear on `txd` in order.
- Write on the same edge as an end-of-STOP pop with count=2 → count stays 2, and the byte order on the line is preserved.
- Assert `rst` low during DATA bit 3 of 0xA5, with 2 bytes queued → `txd`=1 immediately and `fifo_count`=0. After release, nothing is transmitted until a new write.
- Wrap-around: push and transmit 10 bytes 0x00..0x09 in two bursts of 4 and one of 2 → all 10 appear on `txd` in order. The pointers wrap without loss.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-buffered 8N1 UART transmitter: a small circular FIFO behind a valid/ready port,
// drained by a start/data/stop serializer running at a fixed baud rate.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              txd,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow
);

    localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW     = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0]   BaudLast  = CntW'(ClksPerBit - 1);
    localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              overflow_q;
    logic              wr_en;
    logic              pop;
    logic              fifo_empty;

    // Serializer state
    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;

    assign tx_ready   = (count_q != CountFull);
    assign wr_en      = tx_valid && tx_ready;
    assign fifo_empty = (count_q == '0);

    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign txd        = txd_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CountW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= tx_valid && !tx_ready;
        end
    end

    // Pops only ever happen from idle or at the close of a stop bit, so frames chain
    // back-to-back with no idle cycle in between.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_q == BaudLast) begin
                    baud_d  = '0;
                    txd_d   = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = StStart;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule
